// File: rtl/can_bit_destuff.sv
// can_bit_destuff: stream-based CAN bit destuffer.
//
// Sits between the bit-timing sampler and the frame receiver. Consumes one
// sampled bit per i_Bit_Valid strobe. Inside the stuffing region (i_Enable=1)
// it drops the complementary bit inserted after STUFF_LEN equal bits and flags
// a stuff violation when STUFF_LEN+1 equal bits arrive. Outside the region
// every strobed bit passes straight through. All output strobes are
// registered and appear one cycle after the input strobe.
//
// Parameters:
//   STUFF_LEN  equal bits that force a stuff bit (2..15)
//   CNT_W      width of the run-length counter, must be able to hold STUFF_LEN
//
// Ports:
//   i_Clock       system clock, rising edge
//   i_Reset       asynchronous active-high reset
//   i_Bit_Valid   strobe: i_Bit holds a new sampled bit
//   i_Bit         sampled bus bit (0 = dominant)
//   i_Enable      stuffing region active; low = transparent pass-through
//   i_Clear       synchronous clear of the error state and sticky flag
//   o_Bit_Valid   strobe for a forwarded (non-stuff) bit
//   o_Bit         forwarded bit value (0 when o_Bit_Valid is low)
//   o_Stuff_Drop  pulse: a stuff bit was removed
//   o_Stuff_Err   pulse: stuff violation
//   o_Err_Flag    sticky error flag, set with o_Stuff_Err
//   o_Run_Len     current count of equal bits
//   o_Stuff_Cnt   (only with CAN_FD_STUFF_COUNT_EN) modulo-8 count of dropped
//                 stuff bits since i_Enable last rose
//
// Build option: define CAN_FD_STUFF_COUNT_EN to add o_Stuff_Cnt.

module can_bit_destuff #(
  parameter int STUFF_LEN = 5,
  parameter int CNT_W     = 4
) (
  input  logic             i_Clock,
  input  logic             i_Reset,
  input  logic             i_Bit_Valid,
  input  logic             i_Bit,
  input  logic             i_Enable,
  input  logic             i_Clear,
  output logic             o_Bit_Valid,
  output logic             o_Bit,
  output logic             o_Stuff_Drop,
  output logic             o_Stuff_Err,
  output logic             o_Err_Flag,
  output logic [CNT_W-1:0] o_Run_Len
`ifdef CAN_FD_STUFF_COUNT_EN
  ,
  output logic [2:0]       o_Stuff_Cnt
`endif
);

  typedef enum logic [1:0] {IDLE, COUNT, EXPECT_STUFF, ERROR} state_t;

  localparam logic [CNT_W-1:0] RUN_MAX = CNT_W'(STUFF_LEN);
  localparam logic [CNT_W-1:0] RUN_ONE = CNT_W'(1);

  state_t           state, state_n;
  logic [CNT_W-1:0] run, run_n;
  logic             last, last_n;
  logic             fwd_n, fbit_n, drop_n, err_n, flag_n;

  always_comb begin
    state_n = state;
    run_n   = run;
    last_n  = last;
    fwd_n   = 1'b0;
    fbit_n  = 1'b0;
    drop_n  = 1'b0;
    err_n   = 1'b0;
    flag_n  = o_Err_Flag;

    // A violation detected in the same cycle overrides the clear below.
    if (i_Clear) flag_n = 1'b0;

    if (!i_Enable) begin
      // Leaving (or outside) the stuffing region: any pending stuff
      // expectation is abandoned and a concurrent bit passes through,
      // except a bit that arrives together with i_Clear while in ERROR.
      state_n = IDLE;
      run_n   = '0;
      if (i_Bit_Valid && !(state == ERROR && i_Clear)) begin
        fwd_n  = 1'b1;
        fbit_n = i_Bit;
      end
    end else begin
      unique case (state)
        IDLE: begin
          if (i_Bit_Valid) begin
            state_n = COUNT;
            run_n   = RUN_ONE;
            last_n  = i_Bit;
            fwd_n   = 1'b1;
            fbit_n  = i_Bit;
          end
        end
        COUNT: begin
          if (i_Bit_Valid) begin
            fwd_n  = 1'b1;
            fbit_n = i_Bit;
            if (i_Bit == last) begin
              run_n = run + RUN_ONE;
            end else begin
              run_n  = RUN_ONE;
              last_n = i_Bit;
            end
            if (run_n == RUN_MAX) state_n = EXPECT_STUFF;
          end
        end
        EXPECT_STUFF: begin
          if (i_Bit_Valid) begin
            if (i_Bit != last) begin
              // The stuff bit itself starts the next run.
              drop_n  = 1'b1;
              run_n   = RUN_ONE;
              last_n  = i_Bit;
              state_n = COUNT;
            end else begin
              err_n   = 1'b1;
              flag_n  = 1'b1;
              state_n = ERROR;
            end
          end
        end
        ERROR: begin
          if (i_Clear) begin
            state_n = IDLE;
            run_n   = '0;
          end
        end
        default: state_n = IDLE;
      endcase
    end
  end

  always_ff @(posedge i_Clock or posedge i_Reset) begin
    if (i_Reset) begin
      state        <= IDLE;
      run          <= '0;
      last         <= 1'b1;
      o_Bit_Valid  <= 1'b0;
      o_Bit        <= 1'b0;
      o_Stuff_Drop <= 1'b0;
      o_Stuff_Err  <= 1'b0;
      o_Err_Flag   <= 1'b0;
    end else begin
      state        <= state_n;
      run          <= run_n;
      last         <= last_n;
      o_Bit_Valid  <= fwd_n;
      o_Bit        <= fbit_n;
      o_Stuff_Drop <= drop_n;
      o_Stuff_Err  <= err_n;
      o_Err_Flag   <= flag_n;
    end
  end

  assign o_Run_Len = run;

`ifdef CAN_FD_STUFF_COUNT_EN
  // Counter restarts on the rising edge of i_Enable; it cannot coincide with
  // a drop because the FSM is in IDLE on that cycle.
  logic enable_q;

  always_ff @(posedge i_Clock or posedge i_Reset) begin
    if (i_Reset) begin
      enable_q    <= 1'b0;
      o_Stuff_Cnt <= 3'd0;
    end else begin
      enable_q <= i_Enable;
      if (i_Enable && !enable_q) o_Stuff_Cnt <= 3'd0;
      else if (drop_n)           o_Stuff_Cnt <= o_Stuff_Cnt + 3'd1;
    end
  end
`endif

endmodule

// File: tb/tb_can_bit_destuff.sv
// Bench for can_bit_destuff: two instances (STUFF_LEN=5 and STUFF_LEN=3)
// share one stimulus stream and are compared every cycle against a model
// that keeps the raw received-bit history and derives run length from it.

module tb_can_bit_destuff;

  logic clk = 1'b0;
  logic rst;
  logic v, b, en, clr;

  logic       bv5, bit5, drop5, err5, flag5;
  logic [3:0] run5;
  logic       bv3, bit3, drop3, err3, flag3;
  logic [3:0] run3;
  logic [2:0] cnt5, cnt3;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  can_bit_destuff #(.STUFF_LEN(5), .CNT_W(4)) d5 (
    .i_Clock(clk), .i_Reset(rst), .i_Bit_Valid(v), .i_Bit(b),
    .i_Enable(en), .i_Clear(clr),
    .o_Bit_Valid(bv5), .o_Bit(bit5), .o_Stuff_Drop(drop5),
    .o_Stuff_Err(err5), .o_Err_Flag(flag5), .o_Run_Len(run5)
`ifdef CAN_FD_STUFF_COUNT_EN
    , .o_Stuff_Cnt(cnt5)
`endif
  );

  can_bit_destuff #(.STUFF_LEN(3), .CNT_W(4)) d3 (
    .i_Clock(clk), .i_Reset(rst), .i_Bit_Valid(v), .i_Bit(b),
    .i_Enable(en), .i_Clear(clr),
    .o_Bit_Valid(bv3), .o_Bit(bit3), .o_Stuff_Drop(drop3),
    .o_Stuff_Err(err3), .o_Err_Flag(flag3), .o_Run_Len(run3)
`ifdef CAN_FD_STUFF_COUNT_EN
    , .o_Stuff_Cnt(cnt3)
`endif
  );

`ifndef CAN_FD_STUFF_COUNT_EN
  assign cnt5 = 3'd0;
  assign cnt3 = 3'd0;
`endif

  // {cnt[2:0], bv, bit, drop, err, flag, run[3:0]}
  wire [11:0] got5 = {cnt5, bv5, bit5, drop5, err5, flag5, run5};
  wire [11:0] got3 = {cnt3, bv3, bit3, drop3, err3, flag3, run3};
  logic [11:0] e5, e3;

  // ---------------- reference model ----------------
  // History of bits received inside the stuffing region (bit 0 = newest).
  logic [31:0] m_hist [2];
  int          m_len  [2];
  bit          m_err  [2];
  bit          m_flag [2];
  bit          m_enq  [2];
  int          m_cnt  [2];

  function automatic void model_reset();
    for (int k = 0; k < 2; k++) begin
      m_hist[k] = '0; m_len[k] = 0; m_err[k] = 0;
      m_flag[k] = 0;  m_enq[k] = 0; m_cnt[k] = 0;
    end
  endfunction

  // Number of trailing equal bits in the history.
  function automatic int trail(input int k);
    int c = 0;
    if (m_len[k] == 0) return 0;
    while (c < m_len[k] && m_hist[k][c] == m_hist[k][0]) c++;
    return c;
  endfunction

  function automatic void push(input int k, input bit nb);
    m_hist[k] = {m_hist[k][30:0], nb};
    if (m_len[k] < 31) m_len[k]++;
  endfunction

  function automatic logic [11:0] model_step(input int k, input bit iv,
                                             input bit ib, input bit ien,
                                             input bit iclr);
    int L = (k == 0) ? 5 : 3;
    bit fw = 0, fb = 0, dr = 0, er = 0;
    int rl;
    if (ien && !m_enq[k]) m_cnt[k] = 0;
    m_enq[k] = ien;
    if (iclr) m_flag[k] = 0;
    if (m_err[k]) begin
      if (iclr) begin
        m_err[k] = 0; m_len[k] = 0;
      end else if (!ien) begin
        m_err[k] = 0; m_len[k] = 0;
        if (iv) begin fw = 1; fb = ib; end
      end
    end else if (!ien) begin
      m_len[k] = 0;
      if (iv) begin fw = 1; fb = ib; end
    end else if (iv) begin
      if (m_len[k] > 0 && trail(k) == L) begin
        if (ib != m_hist[k][0]) begin
          push(k, ib); dr = 1; m_cnt[k] = (m_cnt[k] + 1) % 8;
        end else begin
          er = 1; m_flag[k] = 1; m_err[k] = 1;
        end
      end else begin
        push(k, ib); fw = 1; fb = ib;
      end
    end
    rl = trail(k);
`ifdef CAN_FD_STUFF_COUNT_EN
    return {3'(m_cnt[k]), fw, fb, dr, er, m_flag[k], 4'(rl)};
`else
    return {3'd0, fw, fb, dr, er, m_flag[k], 4'(rl)};
`endif
  endfunction

  // Apply one clock of stimulus; outputs are sampled 1 time unit after the edge.
  task automatic cyc(input bit iv, input bit ib, input bit ien, input bit iclr);
    v = iv; b = ib; en = ien; clr = iclr;
    e5 = model_step(0, iv, ib, ien, iclr);
    e3 = model_step(1, iv, ib, ien, iclr);
    @(posedge clk); #1;
    v = 0; clr = 0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst = 1; v = 0; b = 0; en = 0; clr = 0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    tests++;
    if (got5 !== 12'd0 || got3 !== 12'd0) begin
      fails++;
      $display("FAIL reset: got5=%b got3=%b required all zero", got5, got3);
    end
    rst = 0;
    @(posedge clk); #1;
  endtask

  task automatic test_stuff_drop();
    bit seq [7] = '{0, 0, 0, 0, 0, 1, 0};
    int nfwd = 0, ndrop = 0;
    for (int i = 0; i < 7; i++) begin
      cyc(1, seq[i], 1, 0);
      tests++;
      if (got5 !== e5 || got3 !== e3) begin
        fails++;
        $display("FAIL stuff_drop[%0d]: got5=%b exp5=%b got3=%b exp3=%b", i, got5, e5, got3, e3);
      end
      nfwd += bv5; ndrop += drop5;
      if (i == 5 || i == 6) begin
        tests++;
        if (run5 !== 4'd1) begin
          fails++;
          $display("FAIL stuff_drop_run[%0d]: got %0d required 1", i, run5);
        end
      end
    end
    tests++;
    if (nfwd != 6 || ndrop != 1) begin
      fails++;
      $display("FAIL stuff_drop_count: fwd=%0d drop=%0d required 6/1", nfwd, ndrop);
    end
    cyc(0, 0, 0, 1);
  endtask

  task automatic test_stuff_error();
    bit saw_err = 0;
    int fwd_in_err = 0;
    for (int i = 0; i < 6; i++) begin
      cyc(1, 1, 1, 0);
      tests++;
      if (got5 !== e5 || got3 !== e3) begin
        fails++;
        $display("FAIL stuff_error[%0d]: got5=%b exp5=%b got3=%b exp3=%b", i, got5, e5, got3, e3);
      end
      if (i == 5) saw_err = err5 && flag5;
    end
    tests++;
    if (!saw_err) begin
      fails++;
      $display("FAIL stuff_error_pulse: err=%b flag=%b required 1/1", err5, flag5);
    end
    for (int i = 0; i < 4; i++) begin
      cyc(1, 1'($urandom_range(0, 1)), 1, 0);
      fwd_in_err += bv5;
      tests++;
      if (got5 !== e5 || got3 !== e3) begin
        fails++;
        $display("FAIL stuff_error_hold[%0d]: got5=%b exp5=%b got3=%b exp3=%b", i, got5, e5, got3, e3);
      end
    end
    tests++;
    if (fwd_in_err != 0) begin
      fails++;
      $display("FAIL stuff_error_nofwd: fwd=%0d required 0", fwd_in_err);
    end
    cyc(1, 0, 1, 1);
    tests++;
    if (got5 !== e5 || flag5 !== 1'b0 || bv5 !== 1'b0) begin
      fails++;
      $display("FAIL stuff_error_clear: got5=%b exp5=%b required flag 0, no fwd", got5, e5);
    end
    cyc(0, 0, 0, 1);
  endtask

  task automatic test_passthrough();
    int nfwd = 0;
    for (int i = 0; i < 8; i++) begin
      cyc(1, 0, 0, 0);
      nfwd += bv5;
      tests++;
      if (got5 !== e5 || got3 !== e3 || run5 !== 4'd0 || drop5 || err5) begin
        fails++;
        $display("FAIL passthrough[%0d]: got5=%b exp5=%b got3=%b exp3=%b", i, got5, e5, got3, e3);
      end
    end
    tests++;
    if (nfwd != 8) begin
      fails++;
      $display("FAIL passthrough_count: fwd=%0d required 8", nfwd);
    end
  endtask

  task automatic test_enable_drop();
    for (int i = 0; i < 5; i++) cyc(1, 0, 1, 0);
    tests++;
    if (got5 !== e5 || run5 !== 4'd5) begin
      fails++;
      $display("FAIL enable_drop_run: got5=%b exp5=%b required run 5", got5, e5);
    end
    cyc(0, 0, 0, 0);
    cyc(1, 0, 0, 0);
    tests++;
    if (got5 !== e5 || got3 !== e3 || bv5 !== 1'b1 || bit5 !== 1'b0 || err5 !== 1'b0) begin
      fails++;
      $display("FAIL enable_drop: got5=%b exp5=%b got3=%b exp3=%b", got5, e5, got3, e3);
    end
    cyc(0, 0, 0, 1);
  endtask

  task automatic test_short_stuff();
    bit seq [7] = '{1, 1, 1, 0, 0, 0, 1};
    int ndrop = 0;
    cyc(0, 0, 0, 0);
    for (int i = 0; i < 7; i++) begin
      cyc(1, seq[i], 1, 0);
      ndrop += drop3;
      tests++;
      if (got5 !== e5 || got3 !== e3) begin
        fails++;
        $display("FAIL short_stuff[%0d]: got5=%b exp5=%b got3=%b exp3=%b", i, got5, e5, got3, e3);
      end
    end
    tests++;
    if (ndrop != 2) begin
      fails++;
      $display("FAIL short_stuff_drops: got %0d required 2", ndrop);
    end
`ifdef CAN_FD_STUFF_COUNT_EN
    tests++;
    if (cnt3 !== 3'd2) begin
      fails++;
      $display("FAIL short_stuff_cnt: got %0d required 2", cnt3);
    end
`endif
    cyc(0, 0, 0, 1);
  endtask

  task automatic test_midframe_reset();
    for (int i = 0; i < 5; i++) cyc(1, 0, 1, 0);
    #3 rst = 1;
    #1;
    tests++;
    if (got5 !== 12'd0 || got3 !== 12'd0) begin
      fails++;
      $display("FAIL midframe_reset: got5=%b got3=%b required all zero", got5, got3);
    end
    model_reset();
    @(posedge clk); #1;
    rst = 0;
    cyc(1, 1, 1, 0);
    tests++;
    if (got5 !== e5 || run5 !== 4'd1 || bv5 !== 1'b1) begin
      fails++;
      $display("FAIL midframe_reset_first: got5=%b exp5=%b required run 1", got5, e5);
    end
    cyc(0, 0, 0, 1);
  endtask

  task automatic test_random();
    bit pb = 1;
    bit ren = 0;
    for (int i = 0; i < 3000; i++) begin
      bit rv, rb, rc;
      rv = ($urandom_range(0, 99) < 60);
      rb = ($urandom_range(0, 99) < 78) ? pb : ~pb;
      if (rv) pb = rb;
      if ($urandom_range(0, 99) < 3) ren = ~ren;
      rc = ($urandom_range(0, 99) < 4);
      cyc(rv, rb, ren, rc);
      tests++;
      if (got5 !== e5 || got3 !== e3) begin
        fails++;
        $display("FAIL random[%0d]: got5=%b exp5=%b got3=%b exp3=%b", i, got5, e5, got3, e3);
      end
    end
  endtask

  initial begin
    test_reset();
    test_stuff_drop();
    test_stuff_error();
    test_passthrough();
    test_enable_drop();
    test_short_stuff();
    test_midframe_reset();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
